// File: rtl/color_sample_sched.sv
// color_sample_sched: sequences the Pmod COLOR interface block through
// wake, settle, measure and evaluate steps. It supports one-shot and periodic
// sampling and can auto-range the sensor gain from the returned counts.
module color_sample_sched #(
  parameter int          PERIOD_CYCLES  = 10000000,
  parameter int          SETTLE_CYCLES  = 2500000,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] SAT_THRESH     = 16'hF000,
  parameter logic [15:0] LOW_THRESH     = 16'h0400,
  parameter int          MAX_ADJ        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        single,
  input  logic        auto_gain,
  input  logic [1:0]  manual_gain,
  input  logic        col_ready,
  input  logic [15:0] col_red,
  input  logic [15:0] col_green,
  input  logic [15:0] col_blue,
  output logic        col_enable,
  output logic [1:0]  col_gain,
  output logic        col_measure,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic [1:0]  gain_used,
  output logic        sample_valid,
  output logic        saturated,
  output logic        timeout_err,
  output logic        busy
);

  localparam int MAX_PS  = (PERIOD_CYCLES > SETTLE_CYCLES) ? PERIOD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_PS > TIMEOUT_CYCLES) ? MAX_PS : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int AW      = $clog2(MAX_ADJ + 2);

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PERIOD_LAST  = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] PERIOD_FULL  = CW'(PERIOD_CYCLES);
  localparam logic [AW-1:0] ADJ_LIMIT    = AW'(MAX_ADJ);

  typedef enum logic [3:0] {
    S_IDLE, S_WAKE, S_SETTLE, S_TRIG, S_WAIT_BUSY,
    S_WAIT_DONE, S_EVAL, S_GAIN_BUSY, S_WAIT_PERIOD
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] state_cnt;
  logic [CW-1:0] period_cnt;
  logic [AW-1:0] adj_cnt;
  logic          oneshot;
  logic          gain_low_seen;
  logic [15:0]   cap_red, cap_green, cap_blue;
  logic [15:0]   max_rg, cap_max;
  logic          start_req, step_down, step_up, manual_change, tmo_hit;
  logic          wait_state, publish, timeout_fire;

  assign start_req     = run | single;
  assign max_rg        = (cap_red > cap_green) ? cap_red : cap_green;
  assign cap_max       = (max_rg > cap_blue) ? max_rg : cap_blue;
  assign step_down     = auto_gain && (adj_cnt < ADJ_LIMIT) && (cap_max >= SAT_THRESH) && (col_gain != 2'd0);
  assign step_up       = auto_gain && (adj_cnt < ADJ_LIMIT) && (cap_max < LOW_THRESH) && (col_gain != 2'd3);
  assign manual_change = !auto_gain && (manual_gain != col_gain);
  assign tmo_hit       = (state_cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decision; an expired wait in any ready-wait state falls back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:        if (start_req) next_state = S_WAKE;
      S_WAKE:        if (col_ready) next_state = S_SETTLE;
                     else if (tmo_hit) next_state = S_IDLE;
      S_SETTLE:      if (state_cnt == SETTLE_LAST) next_state = S_TRIG;
      S_TRIG:        next_state = S_WAIT_BUSY;
      S_WAIT_BUSY:   if (!col_ready) next_state = S_WAIT_DONE;
                     else if (tmo_hit) next_state = S_IDLE;
      S_WAIT_DONE:   if (col_ready) next_state = S_EVAL;
                     else if (tmo_hit) next_state = S_IDLE;
      S_EVAL:        if (step_down || step_up) next_state = S_GAIN_BUSY;
                     else if (run && !oneshot) next_state = S_WAIT_PERIOD;
                     else next_state = S_IDLE;
      S_GAIN_BUSY:   if (gain_low_seen && col_ready) next_state = S_SETTLE;
                     else if (tmo_hit) next_state = S_IDLE;
      S_WAIT_PERIOD: if (!run) next_state = S_IDLE;
                     else if (manual_change) next_state = S_GAIN_BUSY;
                     else if (period_cnt >= PERIOD_LAST) next_state = S_TRIG;
      default:       next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state plus the publish/timeout events.
  always_comb begin
    col_enable   = (state != S_IDLE);
    busy         = (state != S_IDLE);
    col_measure  = (state == S_TRIG);
    wait_state   = (state == S_WAKE) || (state == S_WAIT_BUSY) ||
                   (state == S_WAIT_DONE) || (state == S_GAIN_BUSY);
    publish      = (state == S_EVAL) && !step_down && !step_up;
    timeout_fire = wait_state && (next_state == S_IDLE);
  end

  // Per-state counter restarts on every state change; period counter restarts at each trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_cnt  <= '0;
      period_cnt <= '0;
    end else begin
      if (next_state != state)  state_cnt <= '0;
      else if (state_cnt != '1) state_cnt <= state_cnt + 1'b1;
      if (state == S_TRIG)              period_cnt <= CW'(1);
      else if (period_cnt != PERIOD_FULL) period_cnt <= period_cnt + 1'b1;
    end
  end

  // Gain, adjustment bookkeeping, capture and published results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_gain      <= 2'd0;
      adj_cnt       <= '0;
      oneshot       <= 1'b0;
      gain_low_seen <= 1'b0;
      timeout_err   <= 1'b0;
      cap_red       <= '0;
      cap_green     <= '0;
      cap_blue      <= '0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      gain_used     <= 2'd0;
      saturated     <= 1'b0;
      sample_valid  <= 1'b0;
    end else begin
      sample_valid <= publish;
      if (state == S_IDLE) begin
        if (start_req) begin
          col_gain    <= manual_gain;
          adj_cnt     <= '0;
          oneshot     <= ~run;
          timeout_err <= 1'b0;
        end else if (!auto_gain) begin
          col_gain <= manual_gain;
        end
      end
      if (state == S_WAIT_PERIOD && !auto_gain) col_gain <= manual_gain;
      if (state == S_EVAL) begin
        if (step_down) begin
          col_gain <= col_gain - 2'd1;
          adj_cnt  <= adj_cnt + 1'b1;
        end else if (step_up) begin
          col_gain <= col_gain + 2'd1;
          adj_cnt  <= adj_cnt + 1'b1;
        end else begin
          adj_cnt <= '0;
        end
      end
      if (state != S_GAIN_BUSY) gain_low_seen <= 1'b0;
      else if (!col_ready)      gain_low_seen <= 1'b1;
      if (state == S_WAIT_DONE && col_ready) begin
        cap_red   <= col_red;
        cap_green <= col_green;
        cap_blue  <= col_blue;
      end
      if (publish) begin
        red       <= cap_red;
        green     <= cap_green;
        blue      <= cap_blue;
        gain_used <= col_gain;
        saturated <= (cap_max >= SAT_THRESH);
      end
      if (timeout_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/color_sample_sched.md
Name: color_sample_sched

Overview:
- Sequencer that sits between user logic and the Pmod COLOR interface block.
- Drives that block's enable/gain/measure inputs and watches its ready/red/green/blue outputs.
- Supports one-shot and periodic sampling, with optional auto-ranging of gain from the returned counts.
- Publishes accepted RGB samples with a one-cycle valid pulse and flags sensor timeouts.

Parameters:
PERIOD_CYCLES, 10000000, clk cycles between periodic sample triggers (100 ms at 100 MHz)
SETTLE_CYCLES, 2500000, clk cycles waited after wake or gain change before triggering
TIMEOUT_CYCLES, 1000000, max clk cycles spent waiting on col_ready in any wait state
SAT_THRESH, 16'hF000, max channel count at or above which gain steps down
LOW_THRESH, 16'h0400, max channel count below which gain steps up
MAX_ADJ, 3, gain adjustments allowed per sample before forced publish

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
run  input  1  level; periodic sampling while high
single  input  1  pulse; request one sample (ignored unless in IDLE)
auto_gain  input  1  enable auto-ranging
manual_gain  input  2  gain code used when auto_gain=0, and starting gain
col_ready  input  1  ready from colour interface
col_red  input  16  red count from colour interface
col_green  input  16  green count from colour interface
col_blue  input  16  blue count from colour interface
col_enable  output  1  sensor power/enable to interface
col_gain  output  2  gain code to interface
col_measure  output  1  one-cycle measure strobe
red  output  16  published red
green  output  16  published green
blue  output  16  published blue
gain_used  output  2  gain code of published sample
sample_valid  output  1  one-cycle pulse with new published sample
saturated  output  1  published sample had max >= SAT_THRESH
timeout_err  output  1  sticky sensor timeout flag
busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, col_gain=0, counters 0.
- IDLE:
  - col_enable=0.
  - On run=1 or single=1: clear timeout_err, load col_gain=manual_gain, adj_cnt=0, go WAKE.
  - run takes precedence if both are asserted; the request latches oneshot=~run.
- WAKE: col_enable=1; wait for col_ready=1, then go SETTLE.
- SETTLE: count SETTLE_CYCLES, then go TRIG.
- TRIG: col_measure=1 for exactly one cycle, then go WAIT_BUSY.
- WAIT_BUSY: wait for col_ready=0, then go WAIT_DONE.
- WAIT_DONE: wait for col_ready=1, then register col_* into internal capture regs and go EVAL.
- EVAL (one cycle):
  - max = largest of the three captured counts, unsigned compare.
  - If auto_gain=1, adj_cnt<MAX_ADJ, max>=SAT_THRESH and col_gain>0: col_gain-1, adj_cnt+1, go GAIN_BUSY.
  - Else if auto_gain=1, adj_cnt<MAX_ADJ, max<LOW_THRESH and col_gain<3: col_gain+1, adj_cnt+1, go GAIN_BUSY.
  - Otherwise publish: red/green/blue/gain_used/saturated update, sample_valid=1 for one cycle, adj_cnt=0.
    - Then go WAIT_PERIOD if run=1 and oneshot=0; else go IDLE.
- GAIN_BUSY:
  - Wait for col_ready=0 (interface is writing gain), then col_ready=1, then go SETTLE.
  - The discarded sample is not published.
- WAIT_PERIOD:
  - The period counter starts at the TRIG of the prior sample; TRIG fires when it reaches PERIOD_CYCLES.
  - If already elapsed, TRIG fires next cycle. Then go TRIG.
  - run=0 here goes IDLE immediately.
- Manual gain:
  - When auto_gain=0, col_gain follows manual_gain only in IDLE and WAIT_PERIOD.
  - A change in WAIT_PERIOD goes GAIN_BUSY.
- Stop handling: run falling mid-sample completes the current sample (publish) then goes IDLE.
- Timeout:
  - A single counter runs in WAKE, WAIT_BUSY, WAIT_DONE and GAIN_BUSY, and resets on each state entry.
  - When it reaches TIMEOUT_CYCLES: timeout_err=1, go IDLE (col_enable drops), no publish.
- Published outputs hold their values until the next publish; they are not cleared by IDLE.
- Simultaneous events:
  - single in a non-IDLE state is ignored.
  - col_ready glitching high during WAIT_BUSY does not advance; only a 0 level does.
- Counter widths are sized by $clog2 of the largest cycle parameter. Gain arithmetic saturates at 0/3 by the guards above.

Test Plan:
- single=1, manual_gain=2, auto_gain=0, sensor model returns R/G/B=0x1234/0x2345/0x3456:
  - one col_measure pulse; sample_valid once; red=0x1234, gain_used=2, saturated=0; back to IDLE, col_enable=0.
- auto_gain=1, gain 3, model returns max 0xFFFF at gains 3 and 2, then 0x8000 at gain 1:
  - two GAIN_BUSY passes; published gain_used=1, green=0x8000; only one sample_valid.
- auto_gain=1, gain 0, model always returns 0x0010:
  - gain steps 1, 2, 3 (MAX_ADJ=3); fourth measurement published with gain_used=3.
- run=1, PERIOD_CYCLES=1000, fast model:
  - col_measure pulses exactly 1000 cycles apart for 3 samples.
  - Deassert run mid-WAIT_DONE: one more sample_valid, then IDLE.
- Model never drops col_ready after measure, TIMEOUT_CYCLES=500:
  - timeout_err=1 at 500 cycles after WAIT_BUSY entry; col_enable=0; no sample_valid.
  - Next single clears timeout_err.
- Assert rst during WAIT_DONE: all outputs 0 asynchronously; after release the block sits in IDLE with busy=0.
